// File: rtl/aer_in_arbiter.sv
// ---------------------------------------------------------------------------
// aer_in_arbiter
//
// Round-robin arbiter that shares the single AER_IN req/ack port of the SNN
// core among N_REQ upstream event sources. In IDLE it picks the first
// requesting source at or after the rotating priority pointer. It then
// latches that source's address and runs one 4-phase handshake with the core.
// When the core acknowledges, the winner gets a one-cycle ack_out pulse. Once
// the core drops its acknowledge, priority rotates past the winner.
//
// Parameters:
//   N_REQ        number of upstream requesters (2..8)
//   ADDR_W       AER address width (timestep-marker bits pass through as-is)
//   TIMEOUT_CYC  watchdog limit in cycles (only used with AER_ARB_TIMEOUT_EN)
//
// Ports:
//   CLK          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   req_in       per-source request, held until that source's ack_out pulse
//   addr_in      per-source address, slice i = [i*ADDR_W +: ADDR_W]
//   ack_out      one-hot, one-cycle pulse: event of source i accepted
//   AER_IN_ACK   core acknowledge
//   AER_IN_REQ   request to core
//   AER_IN_ADDR  address to core, stable while AER_IN_REQ is high
//   grant_id     index of the current or last granted source
//   busy         handshake in progress (FSM not idle)
//   err_timeout  sticky watchdog flag (present only with AER_ARB_TIMEOUT_EN)
//
// Configuration macro:
//   AER_ARB_TIMEOUT_EN  when defined, a request the core leaves unanswered
//                       for TIMEOUT_CYC cycles is abandoned. The source gets
//                       no ack_out and must request again, and err_timeout is
//                       set until reset. When undefined, REQ waits
//                       indefinitely and the err_timeout port does not exist.
// ---------------------------------------------------------------------------
module aer_in_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_in,
    input  logic [N_REQ*ADDR_W-1:0]    addr_in,
    output logic [N_REQ-1:0]           ack_out,
    input  logic                       AER_IN_ACK,
    output logic                       AER_IN_REQ,
    output logic [ADDR_W-1:0]          AER_IN_ADDR,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
`ifdef AER_ARB_TIMEOUT_EN
    ,
    output logic                       err_timeout
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    // Elaboration-time guard on the supported configuration range.
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("aer_in_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK_LOW = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                req_q, req_d;
    logic [N_REQ-1:0]    ack_q, ack_d;

`ifdef AER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Unpack the flat address bus so a source can be selected by index.
    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    for (genvar g = 0; g < N_REQ; g++) begin : g_addr_split
        assign addr_arr[g] = addr_in[g*ADDR_W +: ADDR_W];
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: scan sources starting at rr_ptr_q, wrapping to 0.
    // The first requester found wins.
    // -----------------------------------------------------------------------
    logic                win_valid;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     cand;

    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first; otherwise an unassigned path infers a latch.
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!win_valid && req_in[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Priority moves to the source just after the one last served.
    logic [ID_W-1:0]     next_ptr;
    assign next_ptr = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        req_d    = req_q;
        ack_d    = '0;          // ack_out is a single-cycle pulse
`ifdef AER_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // A core acknowledge seen here is spurious and is ignored.
                if (win_valid) begin
                    grant_d = win_idx;
                    addr_d  = addr_arr[win_idx];
                    req_d   = 1'b1;
                    state_d = ST_REQ;
`ifdef AER_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            ST_REQ: begin
                if (AER_IN_ACK) begin
                    req_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_ACK_LOW;
                end
`ifdef AER_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Abandon the event: no ack_out, so the source must
                    // request again. It loses its priority turn.
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            ST_ACK_LOW: begin
                // Requests are not sampled here. The served source drops its
                // request during this wait, so it cannot be granted twice.
                if (!AER_IN_ACK) begin
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            ack_q    <= '0;
`ifdef AER_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here. Every register then
            // updates from the values present before the clock edge,
            // whatever order the statements are written in.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
`ifdef AER_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign AER_IN_REQ  = req_q;
    assign AER_IN_ADDR = addr_q;
    assign ack_out     = ack_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef AER_ARB_TIMEOUT_EN
    assign err_timeout = err_q;
`endif

endmodule
